// File: rtl/sd_drive_arbiter_pkg.sv
// Shared types and sizing helpers for the SD sector-channel arbiter.
// Imported by the round-robin arbiter and the top-level FSM.
package sd_drive_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Width of a counter that must reach `cycles` (at least one bit).
  function automatic int cnt_width(input longint cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Width of a drive index for `n` drives (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sd_drive_arbiter_rr_arbiter.sv
// Combinational rotate-priority arbiter: picks the first requester after
// index `last`, wrapping, so the most recent winner has the lowest priority.
module rr_arbiter
  import sd_drive_arbiter_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);

  logic [IW-1:0] cand;

  // Scan from the farthest candidate to the nearest; the nearest hit wins.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(last) + k) % N);
      if (req[cand]) begin
        gnt_idx   = cand;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sd_drive_arbiter.sv
// Shares one hps_io SD sector channel among NUM_DRIVES floppy controllers:
// round-robin grant, one transfer in flight, buffer routing, abort on remount/timeout.
module sd_drive_arbiter
  import sd_drive_arbiter_pkg::*;
#(
  parameter int          NUM_DRIVES  = 2,
  parameter int          LBA_W       = 32,
  parameter int          BUF_AW      = 9,
  parameter int unsigned TIMEOUT_CYC = 32'd1 << 24
) (
  input  logic                        clk_sys,
  input  logic                        reset,
  input  logic [NUM_DRIVES*LBA_W-1:0] drv_lba,
  input  logic [NUM_DRIVES-1:0]       drv_rd,
  input  logic [NUM_DRIVES-1:0]       drv_wr,
  output logic [NUM_DRIVES-1:0]       drv_done,
  output logic [NUM_DRIVES-1:0]       drv_err,
  output logic [BUF_AW-1:0]           drv_buff_addr,
  output logic [7:0]                  drv_buff_dout,
  output logic [NUM_DRIVES-1:0]       drv_buff_wr,
  input  logic [NUM_DRIVES*8-1:0]     drv_buff_din,
  input  logic [NUM_DRIVES-1:0]       img_mounted,
  output logic [LBA_W-1:0]            sd_lba,
  output logic [NUM_DRIVES-1:0]       sd_rd,
  output logic [NUM_DRIVES-1:0]       sd_wr,
  input  logic                        sd_ack,
  input  logic [BUF_AW-1:0]           sd_buff_addr,
  input  logic [7:0]                  sd_buff_dout,
  input  logic                        sd_buff_wr,
  output logic [7:0]                  sd_buff_din,
  output logic                        busy,
  output state_e                      dbg_state
);

  localparam int GW = idx_width(NUM_DRIVES);
  localparam int CW = cnt_width(longint'(TIMEOUT_CYC));
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYC == 0) ? '0 : CW'(TIMEOUT_CYC - 1);

  // Handshake: a drive raises drv_rd/drv_wr and holds it until its one-cycle
  // drv_done pulse; the HPS answers sd_rd/sd_wr with an sd_ack high window.
  state_e                  state;
  logic [GW-1:0]           g;
  logic [GW-1:0]           last;
  logic [CW-1:0]           cnt;
  logic                    ack_q;

  logic [NUM_DRIVES-1:0]   req;
  logic [GW-1:0]           gnt_idx;
  logic                    gnt_valid;
  logic [NUM_DRIVES-1:0]   gnt_onehot;
  logic [NUM_DRIVES-1:0]   g_onehot;
  logic                    ack_rise;
  logic                    ack_fall;
  logic                    timeout_hit;

  assign req         = drv_rd | drv_wr;
  assign gnt_onehot  = NUM_DRIVES'(1) << gnt_idx;
  assign g_onehot    = NUM_DRIVES'(1) << g;
  assign ack_rise    = sd_ack & ~ack_q;
  assign ack_fall    = ~sd_ack & ack_q;
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt == CNT_LAST);

  rr_arbiter #(.N(NUM_DRIVES)) u_rr (
    .req       (req),
    .last      (last),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      g        <= '0;
      last     <= GW'(NUM_DRIVES - 1);
      cnt      <= '0;
      ack_q    <= 1'b0;
      sd_lba   <= '0;
      sd_rd    <= '0;
      sd_wr    <= '0;
      drv_done <= '0;
      drv_err  <= '0;
    end else begin
      ack_q    <= sd_ack;
      drv_done <= '0;
      drv_err  <= '0;
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            g      <= gnt_idx;
            last   <= gnt_idx;
            sd_lba <= drv_lba[gnt_idx*LBA_W +: LBA_W];
            cnt    <= '0;
            // Read takes precedence when a drive raises both levels.
            if (drv_rd[gnt_idx]) sd_rd <= gnt_onehot;
            else                 sd_wr <= gnt_onehot;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt <= cnt + 1'b1;
          if (ack_rise) begin
            sd_rd <= '0;
            sd_wr <= '0;
            state <= ST_XFER;
          end else if (img_mounted[g] || timeout_hit) begin
            sd_rd    <= '0;
            sd_wr    <= '0;
            drv_done <= g_onehot;
            drv_err  <= g_onehot;
            state    <= ST_DONE;
          end
        end
        ST_XFER: begin
          if (ack_fall) begin
            drv_done <= g_onehot;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Buffer routing is combinational so the HPS byte stream sees no added latency.
  assign drv_buff_addr = sd_buff_addr;
  assign drv_buff_dout = sd_buff_dout;
  assign drv_buff_wr   = (state == ST_XFER && sd_buff_wr && sd_ack) ? g_onehot : '0;
  assign sd_buff_din   = (state == ST_XFER) ? drv_buff_din[g*8 +: 8] : 8'h00;
  assign busy          = (state != ST_IDLE);
  assign dbg_state     = state;

endmodule

// File: tb/tb_sd_drive_arbiter.sv
// Self-checking bench for sd_drive_arbiter: scenario tasks with randomized
// requests checked against a round-robin reference model of the grant rule.
module tb_sd_drive_arbiter;
  import sd_drive_arbiter_pkg::*;

  localparam int N      = 2;
  localparam int LBA_W  = 32;
  localparam int BUF_AW = 9;
  localparam int TO_CYC = 16;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [N*LBA_W-1:0]     drv_lba;
  logic [N-1:0]           drv_rd, drv_wr;
  logic [N-1:0]           drv_done, drv_err;
  logic [BUF_AW-1:0]      drv_buff_addr;
  logic [7:0]             drv_buff_dout;
  logic [N-1:0]           drv_buff_wr;
  logic [N*8-1:0]         drv_buff_din;
  logic [N-1:0]           img_mounted;
  logic [LBA_W-1:0]       sd_lba;
  logic [N-1:0]           sd_rd, sd_wr;
  logic                   sd_ack;
  logic [BUF_AW-1:0]      sd_buff_addr;
  logic [7:0]             sd_buff_dout;
  logic                   sd_buff_wr;
  logic [7:0]             sd_buff_din;
  logic                   busy;
  state_e                 dbg_state;

  int vectors = 0;
  int miscompares = 0;
  int model_last = N - 1;

  logic [7:0]        exp_q[$];
  logic [N-1:0]      obs_wr_q[$];
  logic [BUF_AW-1:0] obs_addr_q[$];
  logic [7:0]        obs_dout_q[$];
  logic [7:0]        obs_din_q[$];

  sd_drive_arbiter #(
    .NUM_DRIVES(N), .LBA_W(LBA_W), .BUF_AW(BUF_AW), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk_sys(clk), .reset(reset), .drv_lba(drv_lba), .drv_rd(drv_rd), .drv_wr(drv_wr),
    .drv_done(drv_done), .drv_err(drv_err), .drv_buff_addr(drv_buff_addr),
    .drv_buff_dout(drv_buff_dout), .drv_buff_wr(drv_buff_wr), .drv_buff_din(drv_buff_din),
    .img_mounted(img_mounted), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    miscompares++;
    $display("FAIL watchdog: got no completion want finish before 1ms");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [N-1:0] onehot(input int i);
    onehot = '0;
    if (i >= 0 && i < N) onehot[i] = 1'b1;
  endfunction

  // First requester after the previous winner, wrapping around the drives.
  function automatic int model_grant(input logic [N-1:0] m);
    for (int k = 1; k <= N; k++)
      if (m[(model_last + k) % N]) return (model_last + k) % N;
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_grant(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if ((sd_rd | sd_wr) != '0) seen = 1'b1;
    end
  endtask

  task automatic ack_on(input int delay);
    repeat (delay) @(posedge clk);
    @(posedge clk); #1 sd_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ack_off();
    @(posedge clk); #1;
    sd_ack = 1'b0;
    sd_buff_wr = 1'b0;
  endtask

  task automatic xfer_bytes(input int n, input int base, input bit is_read);
    logic [7:0] d;
    exp_q.delete(); obs_wr_q.delete(); obs_addr_q.delete(); obs_dout_q.delete(); obs_din_q.delete();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      d = 8'($urandom());
      sd_buff_addr = BUF_AW'(base + i);
      sd_buff_dout = d;
      sd_buff_wr   = is_read;
      exp_q.push_back(d);
      @(negedge clk);
      obs_wr_q.push_back(drv_buff_wr);
      obs_addr_q.push_back(drv_buff_addr);
      obs_dout_q.push_back(drv_buff_dout);
      obs_din_q.push_back(sd_buff_din);
    end
  endtask

  task automatic wait_done(output bit seen, output logic [N-1:0] dv, output logic [N-1:0] ev);
    seen = 1'b0; dv = '0; ev = '0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      if (drv_done != '0) begin seen = 1'b1; dv = drv_done; ev = drv_err; end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    drv_lba = '0; drv_rd = '0; drv_wr = '0; drv_buff_din = '0; img_mounted = '0;
    sd_ack = 1'b0; sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if ((sd_rd | sd_wr) !== '0) begin miscompares++; $display("FAIL rst_sd_req: got %b/%b want 0", sd_rd, sd_wr); end
    vectors++; if (drv_done !== '0 || drv_err !== '0) begin miscompares++; $display("FAIL rst_done: got %b/%b want 0", drv_done, drv_err); end
    vectors++; if (sd_lba !== '0) begin miscompares++; $display("FAIL rst_lba: got %h want 0", sd_lba); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
    vectors++; if (drv_buff_wr !== '0 || sd_buff_din !== 8'h00) begin miscompares++; $display("FAIL rst_buff: got %b/%h want 0", drv_buff_wr, sd_buff_din); end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_read();
    bit seen; logic [N-1:0] dv, ev; int g;
    @(posedge clk); #1;
    drv_lba[0 +: LBA_W] = 32'h10;
    drv_rd = 2'b01;
    g = model_grant(2'b01); model_last = g;
    wait_grant(seen);
    vectors++; if (!seen || sd_rd !== onehot(g) || sd_wr !== '0) begin miscompares++; $display("FAIL sr_grant: got rd=%b wr=%b want rd=%b", sd_rd, sd_wr, onehot(g)); end
    vectors++; if (sd_lba !== 32'h10) begin miscompares++; $display("FAIL sr_lba: got %h want 10", sd_lba); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL sr_busy: got %b want 1", busy); end
    ack_on($urandom_range(0, 5));
    vectors++; if (sd_rd !== '0) begin miscompares++; $display("FAIL sr_ack_drop: got %b want 0", sd_rd); end
    xfer_bytes(512, 0, 1'b1);
    for (int i = 0; i < obs_wr_q.size(); i++) begin
      vectors++; if (obs_wr_q[i] !== onehot(g)) begin miscompares++; $display("FAIL sr_strobe[%0d]: got %b want %b", i, obs_wr_q[i], onehot(g)); end
      vectors++; if (obs_dout_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL sr_dout[%0d]: got %h want %h", i, obs_dout_q[i], exp_q[i]); end
      vectors++; if (obs_addr_q[i] !== BUF_AW'(i)) begin miscompares++; $display("FAIL sr_addr[%0d]: got %h want %h", i, obs_addr_q[i], i); end
    end
    vectors++; if (sd_lba !== 32'h10) begin miscompares++; $display("FAIL sr_lba_hold: got %h want 10", sd_lba); end
    ack_off();
    wait_done(seen, dv, ev);
    vectors++; if (!seen || dv !== onehot(g) || ev !== '0) begin miscompares++; $display("FAIL sr_done: got %b err %b want %b err 0", dv, ev, onehot(g)); end
    drv_rd = '0;
    @(negedge clk);
    vectors++; if (drv_done !== '0) begin miscompares++; $display("FAIL sr_done_once: got %b want 0", drv_done); end
  endtask

  task automatic test_contention();
    bit seen; logic [N-1:0] dv, ev; int g;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) drv_lba[i*LBA_W +: LBA_W] = $urandom();
    drv_rd = 2'b11;
    for (int r = 0; r < 4; r++) begin
      g = model_grant(2'b11); model_last = g;
      wait_grant(seen);
      vectors++; if (!seen || sd_rd !== onehot(g)) begin miscompares++; $display("FAIL ct_grant[%0d]: got %b want %b", r, sd_rd, onehot(g)); end
      vectors++; if (sd_lba !== drv_lba[g*LBA_W +: LBA_W]) begin miscompares++; $display("FAIL ct_lba[%0d]: got %h want %h", r, sd_lba, drv_lba[g*LBA_W +: LBA_W]); end
      ack_on($urandom_range(0, 3));
      xfer_bytes(4, $urandom_range(0, 500), 1'b1);
      for (int i = 0; i < obs_wr_q.size(); i++) begin
        vectors++; if (obs_wr_q[i] !== onehot(g)) begin miscompares++; $display("FAIL ct_strobe[%0d]: got %b want %b", i, obs_wr_q[i], onehot(g)); end
      end
      ack_off();
      wait_done(seen, dv, ev);
      vectors++; if (!seen || dv !== onehot(g) || ev !== '0) begin miscompares++; $display("FAIL ct_done[%0d]: got %b err %b want %b", r, dv, ev, onehot(g)); end
      if (r == 3) drv_rd = '0;
      @(negedge clk);
    end
  endtask

  task automatic test_write();
    bit seen; logic [N-1:0] dv, ev; int g;
    @(posedge clk); #1;
    drv_lba[1*LBA_W +: LBA_W] = 32'h0000_0BAD;
    drv_buff_din[15:8] = 8'hA5;
    drv_wr = 2'b10;
    g = model_grant(2'b10); model_last = g;
    wait_grant(seen);
    vectors++; if (!seen || sd_wr !== onehot(g) || sd_rd !== '0) begin miscompares++; $display("FAIL wr_grant: got rd=%b wr=%b want wr=%b", sd_rd, sd_wr, onehot(g)); end
    ack_on(2);
    vectors++; if (sd_wr !== '0) begin miscompares++; $display("FAIL wr_ack_drop: got %b want 0", sd_wr); end
    xfer_bytes(8, 0, 1'b0);
    for (int i = 0; i < obs_din_q.size(); i++) begin
      vectors++; if (obs_din_q[i] !== 8'hA5) begin miscompares++; $display("FAIL wr_din[%0d]: got %h want a5", i, obs_din_q[i]); end
      vectors++; if (obs_wr_q[i] !== '0) begin miscompares++; $display("FAIL wr_strobe[%0d]: got %b want 0", i, obs_wr_q[i]); end
    end
    ack_off();
    wait_done(seen, dv, ev);
    vectors++; if (!seen || dv !== onehot(g) || ev !== '0) begin miscompares++; $display("FAIL wr_done: got %b err %b want %b", dv, ev, onehot(g)); end
    drv_wr = '0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bit seen, ended; int hi, g; logic [N-1:0] dv, ev;
    @(posedge clk); #1 drv_rd = 2'b01;
    g = model_grant(2'b01); model_last = g;
    wait_grant(seen);
    hi = seen ? 1 : 0; ended = 1'b0; dv = '0; ev = '0;
    for (int c = 0; c < 40 && !ended; c++) begin
      @(negedge clk);
      if (sd_rd != '0) hi++;
      else begin ended = 1'b1; dv = drv_done; ev = drv_err; end
    end
    vectors++; if (hi != TO_CYC) begin miscompares++; $display("FAIL to_cycles: got %0d want %0d", hi, TO_CYC); end
    vectors++; if (dv !== onehot(g) || ev !== onehot(g)) begin miscompares++; $display("FAIL to_done_err: got %b/%b want %b/%b", dv, ev, onehot(g), onehot(g)); end
    drv_rd = '0;
    @(negedge clk);
    vectors++; if (drv_done !== '0 || drv_err !== '0) begin miscompares++; $display("FAIL to_clear: got %b/%b want 0", drv_done, drv_err); end
  endtask

  task automatic test_remount();
    bit seen; logic [N-1:0] dv, ev; int g;
    // Abort in ISSUE; a mount on another drive is ignored first.
    @(posedge clk); #1 drv_rd = 2'b01;
    g = model_grant(2'b01); model_last = g;
    wait_grant(seen);
    @(posedge clk); #1 img_mounted = 2'b10;
    @(posedge clk); #1 img_mounted = 2'b00;
    @(negedge clk);
    vectors++; if (sd_rd !== onehot(g) || drv_done !== '0) begin miscompares++; $display("FAIL rm_other: got rd=%b done=%b want rd=%b", sd_rd, drv_done, onehot(g)); end
    @(posedge clk); #1 img_mounted = 2'b01;
    @(posedge clk); #1 img_mounted = 2'b00;
    @(negedge clk);
    vectors++; if (sd_rd !== '0 || drv_done !== onehot(g) || drv_err !== onehot(g)) begin miscompares++; $display("FAIL rm_issue: got rd=%b done=%b err=%b want 0/%b/%b", sd_rd, drv_done, drv_err, onehot(g), onehot(g)); end
    drv_rd = '0;
    @(negedge clk);
    // Mount during XFER is ignored.
    @(posedge clk); #1 drv_rd = 2'b01;
    g = model_grant(2'b01); model_last = g;
    wait_grant(seen);
    ack_on(1);
    @(posedge clk); #1 img_mounted = 2'b01;
    @(posedge clk); #1 img_mounted = 2'b00;
    xfer_bytes(3, 16, 1'b1);
    ack_off();
    wait_done(seen, dv, ev);
    vectors++; if (!seen || dv !== onehot(g) || ev !== '0) begin miscompares++; $display("FAIL rm_xfer: got %b err %b want %b err 0", dv, ev, onehot(g)); end
    drv_rd = '0;
    @(negedge clk);
    // Ack and mount on the same edge: ack wins.
    @(posedge clk); #1 drv_wr = 2'b10;
    g = model_grant(2'b10); model_last = g;
    wait_grant(seen);
    @(posedge clk); #1 sd_ack = 1'b1; img_mounted = 2'b10;
    @(posedge clk); #1 img_mounted = 2'b00;
    @(negedge clk);
    vectors++; if (sd_wr !== '0 || drv_done !== '0 || busy !== 1'b1) begin miscompares++; $display("FAIL rm_ack_wins: got wr=%b done=%b busy=%b want 0/0/1", sd_wr, drv_done, busy); end
    xfer_bytes(2, 0, 1'b0);
    ack_off();
    wait_done(seen, dv, ev);
    vectors++; if (!seen || dv !== onehot(g) || ev !== '0) begin miscompares++; $display("FAIL rm_ack_done: got %b err %b want %b err 0", dv, ev, onehot(g)); end
    drv_wr = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen; logic [N-1:0] dv, ev; int g;
    @(posedge clk); #1;
    drv_lba[0 +: LBA_W] = 32'h0000_1234;
    drv_rd = 2'b01;
    g = model_grant(2'b01); model_last = g;
    wait_grant(seen);
    ack_on(1);
    xfer_bytes(256, 0, 1'b1);
    @(posedge clk); #1;
    sd_buff_addr = 9'h100; sd_buff_dout = 8'h5A; sd_buff_wr = 1'b1;
    #2 reset = 1'b1;
    #1;
    vectors++; if ((sd_rd | sd_wr) !== '0 || busy !== 1'b0) begin miscompares++; $display("FAIL rm_async_req: got %b/%b busy %b want 0", sd_rd, sd_wr, busy); end
    vectors++; if (drv_buff_wr !== '0 || sd_buff_din !== 8'h00) begin miscompares++; $display("FAIL rm_async_buff: got %b/%h want 0", drv_buff_wr, sd_buff_din); end
    vectors++; if (drv_done !== '0 || drv_err !== '0 || sd_lba !== '0) begin miscompares++; $display("FAIL rm_async_done: got %b/%b lba %h want 0", drv_done, drv_err, sd_lba); end
    vectors++; if (drv_buff_addr !== 9'h100) begin miscompares++; $display("FAIL rm_async_addr: got %h want 100", drv_buff_addr); end
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    repeat (2) begin
      @(negedge clk);
      vectors++; if (drv_done !== '0) begin miscompares++; $display("FAIL rm_no_done: got %b want 0", drv_done); end
    end
    @(posedge clk); #1 reset = 1'b0;
    model_last = N - 1;
    g = model_grant(2'b01); model_last = g;
    wait_grant(seen);
    vectors++; if (!seen || sd_rd !== onehot(g) || sd_lba !== 32'h0000_1234) begin miscompares++; $display("FAIL rm_restart: got %b lba %h want %b lba 1234", sd_rd, sd_lba, onehot(g)); end
    ack_on(0);
    xfer_bytes(16, 0, 1'b1);
    for (int i = 0; i < obs_wr_q.size(); i++) begin
      vectors++; if (obs_wr_q[i] !== onehot(g)) begin miscompares++; $display("FAIL rm_restart_strobe[%0d]: got %b want %b", i, obs_wr_q[i], onehot(g)); end
    end
    ack_off();
    wait_done(seen, dv, ev);
    vectors++; if (!seen || dv !== onehot(g) || ev !== '0) begin miscompares++; $display("FAIL rm_restart_done: got %b err %b want %b", dv, ev, onehot(g)); end
    drv_rd = '0;
    @(negedge clk);
  endtask

  task automatic test_random();
    bit seen, is_read; logic [N-1:0] m, dv, ev, exp_rd, exp_wr; int g, kind, n, base;
    int kinds[N];
    for (int r = 0; r < 16; r++) begin
      @(posedge clk); #1;
      m = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        kinds[i] = $urandom_range(0, 2);
        drv_lba[i*LBA_W +: LBA_W] = $urandom();
        drv_buff_din[i*8 +: 8] = 8'($urandom());
        drv_rd[i] = m[i] && kinds[i] != 1;
        drv_wr[i] = m[i] && kinds[i] != 0;
      end
      g = model_grant(m); model_last = g;
      kind = kinds[g];
      exp_rd = (kind != 1) ? onehot(g) : '0;
      exp_wr = (kind == 1) ? onehot(g) : '0;
      is_read = (kind != 1);
      wait_grant(seen);
      vectors++; if (!seen || sd_rd !== exp_rd || sd_wr !== exp_wr) begin miscompares++; $display("FAIL rnd_grant[%0d]: got %b/%b want %b/%b", r, sd_rd, sd_wr, exp_rd, exp_wr); end
      vectors++; if (sd_lba !== drv_lba[g*LBA_W +: LBA_W]) begin miscompares++; $display("FAIL rnd_lba[%0d]: got %h want %h", r, sd_lba, drv_lba[g*LBA_W +: LBA_W]); end
      if ($urandom_range(0, 1) == 1) begin drv_rd = '0; drv_wr = '0; end
      ack_on($urandom_range(0, 5));
      vectors++; if ((sd_rd | sd_wr) !== '0) begin miscompares++; $display("FAIL rnd_ack_drop[%0d]: got %b/%b want 0", r, sd_rd, sd_wr); end
      n = $urandom_range(1, 6);
      base = $urandom_range(0, 500);
      xfer_bytes(n, base, is_read);
      for (int i = 0; i < obs_wr_q.size(); i++) begin
        vectors++; if (obs_wr_q[i] !== (is_read ? onehot(g) : '0)) begin miscompares++; $display("FAIL rnd_strobe[%0d]: got %b want %b", i, obs_wr_q[i], is_read ? onehot(g) : '0); end
        vectors++; if (obs_din_q[i] !== drv_buff_din[g*8 +: 8]) begin miscompares++; $display("FAIL rnd_din[%0d]: got %h want %h", i, obs_din_q[i], drv_buff_din[g*8 +: 8]); end
        vectors++; if (obs_dout_q[i] !== exp_q[i] || obs_addr_q[i] !== BUF_AW'(base + i)) begin miscompares++; $display("FAIL rnd_pass[%0d]: got %h@%h want %h@%h", i, obs_dout_q[i], obs_addr_q[i], exp_q[i], BUF_AW'(base + i)); end
      end
      ack_off();
      wait_done(seen, dv, ev);
      vectors++; if (!seen || dv !== onehot(g) || ev !== '0) begin miscompares++; $display("FAIL rnd_done[%0d]: got %b err %b want %b", r, dv, ev, onehot(g)); end
      drv_rd = '0; drv_wr = '0;
      @(negedge clk);
      vectors++; if (drv_done !== '0) begin miscompares++; $display("FAIL rnd_done_once[%0d]: got %b want 0", r, drv_done); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write();
    test_timeout();
    test_remount();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
